multicycle_control_fsm: RTL and testbench

Main control unit of the multicycle RV32I core, directly upstream of the ALU. It sequences each instruction through fetch, decode, execute, memory and writeback states. In each state it drives the ALU operation code, datapath mux selects and write enables. It consumes the ALU flags (zero, carry, sign, overflow) to resolve conditional branches.

---
 rtl/multicycle_control_fsm.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/
// memory/writeback and drives ALU op codes, datapath selects and write strobes.
module multicycle_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_rdy,
  input  logic        zero,
  input  logic        carry,
  input  logic        sign,
  input  logic        overflow,
  output logic [3:0]  alu_control,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic [2:0]  imm_src,
  output logic        adr_src,
  output logic        mem_req,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        illegal,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECUTER = 4'd6,  S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,  S_BRANCH   = 4'd9,  S_JAL      = 4'd10, S_JALR    = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011,
    ALU_SLT  = 4'b0101, ALU_PASS = 4'b0111, ALU_SRL = 4'b1000, ALU_SRA = 4'b1001,
    ALU_SLL  = 4'b1010, ALU_XOR = 4'b1100
  } alu_op_t;

  typedef enum logic [6:0] {
    OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011, OP_R    = 7'b0110011,
    OP_I     = 7'b0010011, OP_BR    = 7'b1100011, OP_JAL  = 7'b1101111,
    OP_JALR  = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC = 7'b0010111
  } opcode_t;

  state_t   r_state, w_next;
  opcode_t  w_opcode;
  logic [2:0] w_funct3;
  logic     w_f7b5;
  alu_op_t  w_exec_op;
  logic     w_exec_ill, w_br_take, w_br_ill;
  logic     w_mem_req, w_mem_write, w_ir_write, w_pc_write, w_reg_write, w_illegal;
  logic     w_unused;

  assign w_opcode = opcode_t'(instr[6:0]);
  assign w_funct3 = instr[14:12];
  assign w_f7b5   = instr[30];
  assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= state_t'(RESET_STATE);
    else       r_state <= w_next;
  end

  always_comb begin
    case (w_opcode)
      OP_STORE:          imm_src = 3'b001;
      OP_BR:             imm_src = 3'b010;
      OP_JAL:            imm_src = 3'b011;
      OP_LUI, OP_AUIPC:  imm_src = 3'b100;
      default:           imm_src = 3'b000;
    endcase
  end

  // SUB only exists for R-type; funct7[5] selects SRA for both R and I shifts.
  always_comb begin
    w_exec_ill = 1'b0;
    case (w_funct3)
      3'b000:  w_exec_op = (r_state == S_EXECUTER && w_f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_exec_op = ALU_SLL;
      3'b010:  w_exec_op = ALU_SLT;
      3'b100:  w_exec_op = ALU_XOR;
      3'b101:  w_exec_op = w_f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  w_exec_op = ALU_OR;
      3'b111:  w_exec_op = ALU_AND;
      default: begin
        w_exec_op  = ALU_ADD;
        w_exec_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_br_ill = 1'b0;
    case (w_funct3)
      3'b000:  w_br_take = zero;
      3'b001:  w_br_take = ~zero;
      3'b100:  w_br_take = sign ^ overflow;
      3'b101:  w_br_take = ~(sign ^ overflow);
      3'b110:  w_br_take = carry;
      3'b111:  w_br_take = ~carry;
      default: begin
        w_br_take = 1'b0;
        w_br_ill  = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_next      = r_state;
    alu_control = ALU_ADD;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    adr_src     = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_rdy) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (w_opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECUTER;
          OP_I:              w_next = S_EXECUTEI;
          OP_BR:             w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_ALUWB;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = (w_opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        adr_src   = 1'b1;
        if (mem_rdy) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        adr_src     = 1'b1;
        if (mem_rdy) w_next = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (r_state == S_EXECUTEI) ? 2'b01 : 2'b00;
        alu_control = w_exec_op;
        if (w_exec_ill) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_ALUWB;
        end
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_control = ALU_SUB;
        alu_src_a   = 2'b10;
        w_pc_write  = w_br_take;
        w_illegal   = w_br_ill;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        w_pc_write = 1'b1;
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_next     = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        w_next    = S_JAL;
      end
      S_LUI: begin
        alu_control = ALU_PASS;
        alu_src_b   = 2'b01;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are forced low for the whole reset interval, not just after the state settles.
  assign mem_req   = w_mem_req   & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign pc_write  = w_pc_write  & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign illegal   = w_illegal   & ~reset;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-instruction expected traces
// built from the instruction semantics and checked every cycle.
module tb_multicycle_control_fsm;

  logic        clk, reset, mem_rdy;
  logic [31:0] instr, op_a, op_b, diff;
  logic        zero, carry, sign, overflow;
  logic [3:0]  alu_control, state_dbg;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic        adr_src, mem_req, mem_write, ir_write, pc_write, reg_write, illegal;

  multicycle_control_fsm #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_rdy(mem_rdy),
    .zero(zero), .carry(carry), .sign(sign), .overflow(overflow),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .adr_src(adr_src),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .illegal(illegal),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU flags as the datapath would produce them for op_a - op_b
  assign diff     = op_a - op_b;
  assign zero     = (diff == 32'd0);
  assign carry    = (op_a < op_b);
  assign sign     = diff[31];
  assign overflow = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);

  typedef struct {
    logic [23:0] e;
    logic [23:0] m;
    string       nm;
  } exp_t;

  exp_t        q[$];
  logic [8:0]  hist[$];
  int          n_vec = 0, n_miss = 0;
  exp_t        cx;
  logic [23:0] cact;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      cx   = q.pop_front();
      cact = {state_dbg, alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
              mem_req, mem_write, ir_write, pc_write, reg_write, illegal};
      n_vec++;
      if ((cact & cx.m) !== (cx.e & cx.m)) begin
        n_miss++;
        $display("FAIL %s: got %h want %h (care %h)", cx.nm, cact & cx.m, cx.e & cx.m, cx.m);
      end
      hist.push_back({pc_write, state_dbg, alu_control});
    end
  end

  function automatic logic [2:0] imm_of(input logic [6:0] opc);
    case (opc)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b1101111:             return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  // funct3 -> ALU code; -1 marks the unsupported sltu/sltiu slot
  function automatic int op_of(input logic [2:0] f3, input logic b30, input bit rt);
    case (f3)
      3'd0:    return (rt && b30) ? 1 : 0;
      3'd1:    return 10;
      3'd2:    return 5;
      3'd3:    return -1;
      3'd4:    return 12;
      3'd5:    return b30 ? 9 : 8;
      3'd6:    return 3;
      default: return 2;
    endcase
  endfunction

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock of expectation; -1 in a field means the value is unconstrained there.
  // str = {mem_req, mem_write, ir_write, pc_write, reg_write, illegal}
  task automatic cyc(input string nm, input int st, input int alu, input int sa, input int sb,
                     input int rs, input int adr, input logic [5:0] str, input bit rdy);
    exp_t x;
    mem_rdy = rdy;
    x.nm = nm;
    x.e  = {4'(st), 4'(alu < 0 ? 0 : alu), 2'(sa < 0 ? 0 : sa), 2'(sb < 0 ? 0 : sb),
            2'(rs < 0 ? 0 : rs), imm_of(instr[6:0]), (adr == 1), str};
    x.m  = {4'hF, (alu < 0) ? 4'h0 : 4'hF, (sa < 0) ? 2'b00 : 2'b11, (sb < 0) ? 2'b00 : 2'b11,
            (rs < 0) ? 2'b00 : 2'b11, 3'b111, (adr < 0) ? 1'b0 : 1'b1, 6'h3F};
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic aluwb(input string nm);
    cyc({nm, ".WB"}, 8, -1, -1, -1, 0, -1, 6'b000010, 1'b0);
  endtask

  task automatic do_instr(input string nm, input logic [31:0] ins, input int fstall,
                          input int mstall, input logic [31:0] a, input logic [31:0] b);
    logic [6:0] opc;
    logic [2:0] f3;
    bit         known, rt, taken, bill;
    int         op;
    opc   = ins[6:0];
    f3    = ins[14:12];
    instr = ins;
    op_a  = a;
    op_b  = b;
    known = (opc inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                         7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111});
    for (int i = 0; i < fstall; i++) cyc({nm, ".Fs"}, 0, -1, -1, -1, -1, 0, 6'b100000, 1'b0);
    cyc({nm, ".F"}, 0, 0, 0, 2, 2, 0, 6'b101100, 1'b1);
    cyc({nm, ".D"}, 1, 0, 1, 1, -1, -1, known ? 6'b000000 : 6'b000001, 1'b0);
    if (!known) return;
    case (opc)
      7'b0000011, 7'b0100011: begin
        cyc({nm, ".MA"}, 2, 0, 2, 1, -1, -1, 6'b000000, 1'b1);
        if (opc == 7'b0000011) begin
          for (int i = 0; i < mstall; i++) cyc({nm, ".MRs"}, 3, -1, -1, -1, 0, 1, 6'b100000, 1'b0);
          cyc({nm, ".MR"}, 3, -1, -1, -1, 0, 1, 6'b100000, 1'b1);
          cyc({nm, ".MWB"}, 4, -1, -1, -1, 1, -1, 6'b000010, 1'b1);
        end else begin
          for (int i = 0; i < mstall; i++) cyc({nm, ".MWs"}, 5, -1, -1, -1, -1, 1, 6'b110000, 1'b0);
          cyc({nm, ".MW"}, 5, -1, -1, -1, -1, 1, 6'b110000, 1'b1);
        end
      end
      7'b0110011, 7'b0010011: begin
        rt = (opc == 7'b0110011);
        op = op_of(f3, ins[30], rt);
        if (op < 0) begin
          cyc({nm, ".EX"}, rt ? 6 : 7, -1, 2, rt ? 0 : 1, -1, -1, 6'b000001, 1'b0);
        end else begin
          cyc({nm, ".EX"}, rt ? 6 : 7, op, 2, rt ? 0 : 1, -1, -1, 6'b000000, 1'b1);
          aluwb(nm);
        end
      end
      7'b1100011: begin
        bill = (f3 == 3'b010 || f3 == 3'b011);
        case (f3)
          3'd0:    taken = (a == b);
          3'd1:    taken = (a != b);
          3'd4:    taken = ($signed(a) < $signed(b));
          3'd5:    taken = ($signed(a) >= $signed(b));
          3'd6:    taken = (a < b);
          3'd7:    taken = (a >= b);
          default: taken = 1'b0;
        endcase
        cyc({nm, ".BR"}, 9, 1, 2, 0, 0, -1, {3'b000, taken, 1'b0, bill}, 1'b1);
      end
      7'b1101111, 7'b1100111: begin
        if (opc == 7'b1100111) cyc({nm, ".JR"}, 11, 0, 2, 1, -1, -1, 6'b000000, 1'b1);
        cyc({nm, ".J"}, 10, 0, 1, 2, 0, -1, 6'b000100, 1'b0);
        aluwb(nm);
      end
      7'b0110111: begin
        cyc({nm, ".LUI"}, 12, 7, -1, 1, -1, -1, 6'b000000, 1'b1);
        aluwb(nm);
      end
      default: aluwb(nm);
    endcase
  endtask

  int n;

  initial begin
    reset = 1'b1; mem_rdy = 1'b1; instr = 32'h0; op_a = '0; op_b = '0;
    #2;
    lit("rst_state", 32'(state_dbg), 32'd0);
    lit("rst_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write, illegal}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    do_instr("addi", 32'h00500093, 2, 0, 0, 0);
    n = hist.size();
    lit("addi_seq", 32'({hist[n-4][7:4], hist[n-3][7:4], hist[n-2][7:4], hist[n-1][7:4]}), 32'h0178);
    do_instr("sub", 32'h40208133, 0, 0, 0, 0);
    n = hist.size();
    lit("sub_op", 32'(hist[n-2]), 32'h061);
    do_instr("srai", 32'h4010d093, 0, 0, 0, 0);
    n = hist.size();
    lit("srai_op", 32'(hist[n-2]), 32'h079);
    do_instr("addi_neg", 32'hfff08093, 0, 0, 0, 0);
    do_instr("add", 32'h002081b3, 0, 0, 0, 0);
    do_instr("sll", 32'h002091b3, 0, 0, 0, 0);
    do_instr("slt", 32'h0020a1b3, 0, 0, 0, 0);
    do_instr("xor", 32'h0020c1b3, 0, 0, 0, 0);
    do_instr("srl", 32'h0020d1b3, 0, 0, 0, 0);
    do_instr("sra", 32'h4020d1b3, 0, 0, 0, 0);
    do_instr("or", 32'h0020e1b3, 0, 0, 0, 0);
    do_instr("and", 32'h0020f1b3, 0, 0, 0, 0);
    do_instr("slli", 32'h00109093, 0, 0, 0, 0);
    do_instr("srli", 32'h0010d093, 0, 0, 0, 0);
    do_instr("slti", 32'h0050a093, 0, 0, 0, 0);
    do_instr("andi", 32'h0ff0f093, 0, 0, 0, 0);

    do_instr("bne", 32'h00209463, 0, 0, 32'd1, 32'd2);
    n = hist.size();
    lit("bne_pcw", 32'(hist[n-1]), 32'h191);
    do_instr("beq", 32'h00208463, 0, 0, 32'd1, 32'd2);
    n = hist.size();
    lit("beq_pcw", 32'(hist[n-1]), 32'h091);
    do_instr("beq_eq", 32'h00208463, 0, 0, 32'd7, 32'd7);
    do_instr("bltu", 32'h0020e463, 0, 0, 32'd1, 32'd5);
    do_instr("bltu_n", 32'h0020e463, 0, 0, 32'hFFFFFFFF, 32'd1);
    do_instr("blt", 32'h0020c463, 0, 0, 32'hFFFFFFFF, 32'd1);
    do_instr("bge_ov", 32'h0020d463, 0, 0, 32'h80000000, 32'd1);
    do_instr("bge", 32'h0020d463, 0, 0, 32'd3, 32'd3);
    do_instr("bgeu", 32'h0020f463, 0, 0, 32'd5, 32'd5);
    do_instr("br010", 32'h0020a463, 0, 0, 32'd1, 32'd1);

    do_instr("lw", 32'h0000a083, 0, 3, 0, 0);
    do_instr("sw", 32'h00112023, 1, 2, 0, 0);
    do_instr("jal", 32'h008000ef, 0, 0, 0, 0);
    do_instr("jalr", 32'h000080e7, 0, 0, 0, 0);
    do_instr("lui", 32'h000010b7, 0, 0, 0, 0);
    do_instr("auipc", 32'h00001097, 0, 0, 0, 0);
    do_instr("ill_op", 32'h0000007f, 0, 0, 0, 0);
    do_instr("sltu", 32'h0020b1b3, 0, 0, 0, 0);

    instr = 32'h00112023;
    cyc("rw.F", 0, 0, 0, 2, 2, 0, 6'b101100, 1'b1);
    cyc("rw.D", 1, 0, 1, 1, -1, -1, 6'b000000, 1'b0);
    cyc("rw.MA", 2, 0, 2, 1, -1, -1, 6'b000000, 1'b0);
    cyc("rw.MW", 5, -1, -1, -1, -1, 1, 6'b110000, 1'b0);
    #1;
    lit("rw_pre", 32'({state_dbg, mem_write}), 32'h0B);
    reset   = 1'b1;
    mem_rdy = 1'b1;
    #1;
    lit("rw_state", 32'(state_dbg), 32'd0);
    lit("rw_strobes", 32'({mem_req, mem_write, ir_write, pc_write, reg_write, illegal}), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    do_instr("post_rst", 32'h00500093, 0, 0, 0, 0);
    cyc("tail.F", 0, -1, -1, -1, -1, 0, 6'b100000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
